decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 The block SHALL have parameter FANOUT, default 64, meaning the width of the one-hot output word (legal range 2..256).
REQ-002 The block SHALL have parameter IO_SIZE, default $clog2(FANOUT), meaning the width of the select input.
REQ-003 The block SHALL have parameter STAGES, default 2, meaning the number of register stages from input to output (legal range 1..4).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port inpBus, input, IO_SIZE bits: the select value to decode.
REQ-007 The block SHALL have port enable, input, 1 bit: decode gate, sampled together with inpBus.
REQ-008 The block SHALL have port inValid, input, 1 bit: inpBus/enable hold a transfer.
REQ-009 The block SHALL have port inReady, output, 1 bit: the block accepts a transfer this cycle.
REQ-010 The block SHALL have port flush, input, 1 bit: synchronous discard of all in-flight words.
REQ-011 The block SHALL have port outBus, output, FANOUT bits: the registered decoded word.
REQ-012 The block SHALL have port outValid, output, 1 bit: outBus holds a word.
REQ-013 The block SHALL have port outReady, input, 1 bit: the consumer takes outBus this cycle.
REQ-014 The block SHALL have port rangeErr, output, 1 bit: sticky flag, set when an out-of-range select is accepted.
REQ-015 The block SHALL have port hitCount, output, 16 bits: saturating count of delivered non-zero words.

Function
REQ-016 Accept: a transfer SHALL occur when inValid && inReady; stage 0 SHALL capture the decoded word and its valid bit.
REQ-017 Decode: the captured word SHALL have bit k = 1 iff enable = 1, inpBus == k and k < FANOUT; all other bits 0.
REQ-018 Out of range: with enable = 1 and inpBus >= FANOUT, the word SHALL be all zeros and rangeErr SHALL set on acceptance.
REQ-019 Pipeline: stage i (i = 1..STAGES-1) SHALL load from stage i-1 when stage i is empty or advancing; the last stage drives outBus and outValid.
REQ-020 Advance rule: a stage advances when it is empty, or when the next stage is empty or advancing; the last stage advances when !outValid || outReady.
REQ-021 inReady SHALL equal the stage-0 advance condition, computed combinationally with no dependency on inValid.
REQ-022 Latency: with outReady held at 1, a word accepted at edge N SHALL appear on outBus with outValid = 1 after edge N+STAGES-1.
REQ-023 Throughput: with outReady held at 1, the block SHALL accept one word per cycle with no bubbles.
REQ-024 Stall: while outValid && !outReady, outBus and outValid SHALL hold stable; the pipeline SHALL fill to at most STAGES words, then drop inReady.
REQ-025 Ordering: words SHALL leave in acceptance order; none SHALL be dropped or duplicated, except on flush or reset.
REQ-026 Flush: when flush = 1, all stage valid bits SHALL clear at the edge, and any same-cycle input transfer SHALL be discarded.
REQ-027 Flush: rangeErr and hitCount SHALL be unaffected by flush.
REQ-028 Flush: an acceptance in the same cycle as flush SHALL NOT set rangeErr.
REQ-029 Counter: hitCount SHALL increment by 1 on each outValid && outReady cycle with outBus != 0, and saturate at 16'hFFFF.
REQ-030 Simultaneous events: the counter and the pipeline SHALL update correctly when handshakes, flush and saturation coincide in one cycle.
REQ-031 Non-power-of-two FANOUT SHALL be supported; a power-of-two FANOUT SHALL never raise rangeErr.

Reset
REQ-032 While reset = 1, all stage valid bits, outValid, rangeErr and hitCount SHALL be 0, and outBus SHALL be all zeros, immediately and without waiting for clk.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight words.
REQ-034 inReady SHALL be 1 during reset and in the first cycle after reset deasserts.

Verification
REQ-035 FANOUT=64, STAGES=2, outReady=1: send inpBus=0,1,...,63 back-to-back with enable=1 -> outBus=1<<k in order, starting one cycle after the first accept, no bubbles; hitCount=64.
REQ-036 enable=0 with inpBus=5 -> outBus=0 with outValid=1; hitCount unchanged; rangeErr=0.
REQ-037 FANOUT=48, inpBus=50, enable=1 -> outBus=0 and rangeErr=1; rangeErr stays 1 until reset.
REQ-038 STAGES=3, outReady=0, stream 5 words -> exactly 3 accepted and inReady=0; then raise outReady -> the 3 words emerge in order and intake resumes.
REQ-039 With 2 words in flight, assert flush for one cycle together with inValid=1 -> outValid=0 the next cycle; the flushed-cycle word is never output.
REQ-040 Preload hitCount to 16'hFFFE via 2 deliveries from the top, then deliver 3 hits -> hitCount=16'hFFFF; assert reset mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/decode_pipe.sv
// Pipelined one-hot decoder with valid/ready flow control, flush, a sticky
// out-of-range flag and a saturating count of delivered non-zero words.
module decode_pipe #(
    parameter int FANOUT  = 64,
    parameter int IO_SIZE = $clog2(FANOUT),
    parameter int STAGES  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [IO_SIZE-1:0] inpBus,
    input  logic               enable,
    input  logic               inValid,
    output logic               inReady,
    input  logic               flush,
    output logic [FANOUT-1:0]  outBus,
    output logic               outValid,
    input  logic               outReady,
    output logic               rangeErr,
    output logic [15:0]        hitCount
);

    logic [FANOUT-1:0] stageData_q [STAGES];
    logic [STAGES-1:0] stageValid_q;
    logic [STAGES-1:0] advance;
    logic [FANOUT-1:0] decoded_d;
    logic              outOfRange;
    logic              acceptFire;
    logic              deliverHit;
    logic              rangeErr_q;
    logic              rangeErr_d;
    logic [15:0]       hitCount_q;
    logic [15:0]       hitCount_d;

    // Advance permission ripples back from the consumer, so a full pipeline
    // whose output is being taken can still accept a new word every cycle.
    always_comb begin
        logic chain;
        chain                = !stageValid_q[STAGES-1] || outReady;
        advance              = '0;
        advance[STAGES-1]    = chain;
        for (int i = STAGES - 2; i >= 0; i--) begin
            chain      = !stageValid_q[i] || chain;
            advance[i] = chain;
        end
    end

    always_comb begin
        logic [31:0] selWide;
        selWide    = 32'(inpBus);
        decoded_d  = '0;
        outOfRange = enable && (selWide >= 32'(FANOUT));
        for (int k = 0; k < FANOUT; k++) begin
            decoded_d[k] = enable && (selWide == 32'(k));
        end
    end

    assign inReady    = advance[0];
    assign outBus     = stageData_q[STAGES-1];
    assign outValid   = stageValid_q[STAGES-1];
    assign acceptFire = inValid && inReady && !flush;
    assign deliverHit = outValid && outReady && (|outBus);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stageValid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                stageData_q[i] <= '0;
            end
        end else if (flush) begin
            stageValid_q <= '0;
        end else begin
            if (advance[0]) begin
                stageValid_q[0] <= inValid;
                stageData_q[0]  <= decoded_d;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (advance[i]) begin
                    stageValid_q[i] <= stageValid_q[i-1];
                    stageData_q[i]  <= stageData_q[i-1];
                end
            end
        end
    end

    // Status registers keep counting through a flush; only reset clears them.
    always_comb begin
        rangeErr_d = rangeErr_q || (acceptFire && outOfRange);
        hitCount_d = hitCount_q;
        if (deliverHit && (hitCount_q != 16'hFFFF)) begin
            hitCount_d = hitCount_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rangeErr_q <= 1'b0;
            hitCount_q <= '0;
        end else begin
            rangeErr_q <= rangeErr_d;
            hitCount_q <= hitCount_d;
        end
    end

    assign rangeErr = rangeErr_q;
    assign hitCount = hitCount_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard bench for decode_pipe: instance A (FANOUT=64, STAGES=2) and
// instance B (FANOUT=48, STAGES=3) share a clock and have separate queues.
module tb_decode_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    logic        resetA, enableA, inValidA, inReadyA, flushA, outValidA, outReadyA, rangeErrA;
    logic [5:0]  inpBusA;
    logic [63:0] outBusA;
    logic [15:0] hitCountA;

    logic        resetB, enableB, inValidB, inReadyB, flushB, outValidB, outReadyB, rangeErrB;
    logic [5:0]  inpBusB;
    logic [47:0] outBusB;
    logic [15:0] hitCountB;

    logic [63:0] qA[$];
    logic [63:0] qB[$];

    int outCountA   = 0;
    int firstOutA   = 0;
    int lastOutA    = 0;
    int lastAccA    = 0;
    int firstAccA   = 0;
    int acceptedB   = 0;
    logic [47:0] holdB;

    decode_pipe #(.FANOUT(64), .STAGES(2)) dutA (
        .clk(clk), .reset(resetA), .inpBus(inpBusA), .enable(enableA),
        .inValid(inValidA), .inReady(inReadyA), .flush(flushA),
        .outBus(outBusA), .outValid(outValidA), .outReady(outReadyA),
        .rangeErr(rangeErrA), .hitCount(hitCountA)
    );

    decode_pipe #(.FANOUT(48), .STAGES(3)) dutB (
        .clk(clk), .reset(resetB), .inpBus(inpBusB), .enable(enableB),
        .inValid(inValidB), .inReady(inReadyB), .flush(flushB),
        .outBus(outBusB), .outValid(outValidB), .outReady(outReadyB),
        .rangeErr(rangeErrB), .hitCount(hitCountB)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got timeout expected handshake", name);
    endtask

    // Monitors pop the oldest expected word whenever a delivery handshake is seen.
    always @(negedge clk) begin
        if (!resetA && outValidA && outReadyA) begin
            if (qA.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL monA unexpected word: got %h expected none", outBusA);
            end else begin
                if (outCountA == 0) firstOutA = cyc;
                lastOutA = cyc;
                outCountA++;
                checkOutput("monA word", outBusA, qA.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!resetB && outValidB && outReadyB) begin
            if (qB.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL monB unexpected word: got %h expected none", outBusB);
            end else begin
                checkOutput("monB word", 64'(outBusB), qB.pop_front());
            end
        end
    end

    task automatic applyStimulusA(input logic [5:0] sel, input logic en, input logic [63:0] exp);
        int waitCnt;
        inpBusA  = sel;
        enableA  = en;
        inValidA = 1'b1;
        @(negedge clk);
        waitCnt = 0;
        while (!inReadyA && waitCnt < 40) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!inReadyA) begin
            timeoutFail("sendA");
        end else begin
            lastAccA = cyc;
            if (!flushA) qA.push_back(exp);
        end
        @(posedge clk);
        #1;
        inValidA = 1'b0;
    endtask

    task automatic applyStimulusB(input logic [5:0] sel, input logic en, input logic [63:0] exp);
        int waitCnt;
        inpBusB  = sel;
        enableB  = en;
        inValidB = 1'b1;
        @(negedge clk);
        waitCnt = 0;
        while (!inReadyB && waitCnt < 40) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!inReadyB) begin
            timeoutFail("sendB");
        end else if (!flushB) begin
            qB.push_back(exp);
        end
        @(posedge clk);
        #1;
        inValidB = 1'b0;
    endtask

    task automatic drainA();
        int n = 0;
        while (qA.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (qA.size() != 0) timeoutFail("drainA");
        @(posedge clk);
        #1;
    endtask

    task automatic drainB();
        int n = 0;
        while (qB.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (qB.size() != 0) timeoutFail("drainB");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: got time limit expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetA = 1'b1; resetB = 1'b1;
        inpBusA = '0; enableA = 1'b0; inValidA = 1'b0; flushA = 1'b0; outReadyA = 1'b1;
        inpBusB = '0; enableB = 1'b0; inValidB = 1'b0; flushB = 1'b0; outReadyB = 1'b1;
        #2;
        checkOutput("rst outValidA", 64'(outValidA), 64'd0);
        checkOutput("rst outBusA", outBusA, 64'd0);
        checkOutput("rst hitCountA", 64'(hitCountA), 64'd0);
        checkOutput("rst rangeErrA", 64'(rangeErrA), 64'd0);
        checkOutput("rst inReadyA", 64'(inReadyA), 64'd1);
        checkOutput("rst rangeErrB", 64'(rangeErrB), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetA = 1'b0; resetB = 1'b0;
        checkOutput("post-rst inReadyA", 64'(inReadyA), 64'd1);

        // Full sweep, back to back, with consumer always ready.
        outCountA = 0;
        for (int k = 0; k < 64; k++) begin
            applyStimulusA(k[5:0], 1'b1, 64'd1 << k);
            if (k == 0) firstAccA = lastAccA;
        end
        drainA();
        checkOutput("sweep count", 64'(outCountA), 64'd64);
        checkOutput("sweep latency", 64'(firstOutA - firstAccA), 64'd2);
        checkOutput("sweep no bubbles", 64'(lastOutA - firstOutA), 64'd63);
        checkOutput("sweep hitCount", 64'(hitCountA), 64'd64);

        // Disabled decode delivers a zero word that does not count.
        applyStimulusA(6'd5, 1'b0, 64'd0);
        drainA();
        checkOutput("disabled hitCount", 64'(hitCountA), 64'd64);
        checkOutput("pow2 rangeErrA", 64'(rangeErrA), 64'd0);

        // Flush with two words in flight and a same-cycle transfer.
        applyStimulusA(6'd3, 1'b1, 64'd1 << 3);
        applyStimulusA(6'd7, 1'b1, 64'd1 << 7);
        flushA = 1'b1;
        applyStimulusA(6'd9, 1'b1, 64'd1 << 9);
        flushA = 1'b0;
        qA.delete();
        checkOutput("flush outValidA", 64'(outValidA), 64'd0);
        applyStimulusA(6'd11, 1'b1, 64'd1 << 11);
        drainA();
        checkOutput("flush hitCountA", 64'(hitCountA), 64'd66);

        // Out-of-range during flush must not set the flag.
        flushB = 1'b1;
        applyStimulusB(6'd50, 1'b1, 64'd0);
        flushB = 1'b0;
        qB.delete();
        checkOutput("flush rangeErrB", 64'(rangeErrB), 64'd0);
        applyStimulusB(6'd47, 1'b1, 64'd1 << 47);
        applyStimulusB(6'd0, 1'b1, 64'd1);
        drainB();
        checkOutput("top bit rangeErrB", 64'(rangeErrB), 64'd0);
        applyStimulusB(6'd50, 1'b1, 64'd0);
        drainB();
        checkOutput("oor rangeErrB", 64'(rangeErrB), 64'd1);
        applyStimulusB(6'd2, 1'b1, 64'd4);
        drainB();
        checkOutput("sticky rangeErrB", 64'(rangeErrB), 64'd1);
        checkOutput("hitCountB", 64'(hitCountB), 64'd3);

        // Stall: three-deep pipeline fills and then refuses input.
        outReadyB = 1'b0;
        acceptedB = 0;
        for (int k = 0; k < 5; k++) begin
            inpBusB  = 6'(10 + k);
            enableB  = 1'b1;
            inValidB = 1'b1;
            @(negedge clk);
            if (inReadyB) begin
                qB.push_back(64'd1 << (10 + k));
                acceptedB++;
            end
            @(posedge clk);
            #1;
        end
        inValidB = 1'b0;
        checkOutput("stall accepted", 64'(acceptedB), 64'd3);
        checkOutput("stall inReadyB", 64'(inReadyB), 64'd0);
        @(negedge clk);
        holdB = outBusB;
        repeat (3) @(negedge clk);
        checkOutput("stall hold word", 64'(outBusB), 64'd1 << 10);
        checkOutput("stall stable", 64'(outBusB), 64'(holdB));
        checkOutput("stall outValidB", 64'(outValidB), 64'd1);
        @(posedge clk);
        #1;
        outReadyB = 1'b1;
        drainB();
        applyStimulusB(6'd20, 1'b1, 64'd1 << 20);
        drainB();
        checkOutput("resume hitCountB", 64'(hitCountB), 64'd7);

        // Saturation: reset A, then deliver enough hits to reach the top.
        resetA = 1'b1;
        qA.delete();
        @(posedge clk);
        #1;
        resetA = 1'b0;
        for (int i = 0; i < 65534; i++) begin
            applyStimulusA(i[5:0], 1'b1, 64'd1 << i[5:0]);
        end
        drainA();
        checkOutput("preload hitCountA", 64'(hitCountA), 64'hFFFE);
        applyStimulusA(6'd1, 1'b1, 64'd1 << 1);
        applyStimulusA(6'd2, 1'b1, 64'd1 << 2);
        applyStimulusA(6'd3, 1'b1, 64'd1 << 3);
        drainA();
        checkOutput("saturated hitCountA", 64'(hitCountA), 64'hFFFF);

        // Asynchronous reset with words in flight.
        applyStimulusA(6'd4, 1'b1, 64'd1 << 4);
        applyStimulusA(6'd5, 1'b1, 64'd1 << 5);
        #2;
        resetA = 1'b1;
        #1;
        qA.delete();
        checkOutput("async outValidA", 64'(outValidA), 64'd0);
        checkOutput("async outBusA", outBusA, 64'd0);
        checkOutput("async hitCountA", 64'(hitCountA), 64'd0);
        checkOutput("async rangeErrA", 64'(rangeErrA), 64'd0);
        checkOutput("async inReadyA", 64'(inReadyA), 64'd1);
        @(posedge clk);
        #1;
        resetA = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("after rst outValidA", 64'(outValidA), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
